irq_cause_ctrl: RTL and testbench
=================================

Name: irq_cause_ctrl

Overview:
- Parametrised interrupt cause controller; successor to the fixed single-cause block.
- Collects N_SRC interrupt sources and holds per-source pending and enable state.
- Arbitrates the sources by fixed priority and presents one interrupt with an encoded cause word.
- Runs a claim/complete handshake with the core-side trap logic; sits between peripheral interrupt lines and the core.

Parameters:
- N_SRC, 4, number of interrupt sources (1..32).
- CAUSE_W, 6, io_irq_cause width; MSB is the interrupt flag, low CAUSE_W-1 bits hold the source index. Requires 2^(CAUSE_W-1) >= N_SRC.
- EDGE, 1, 1 = rising-edge sources latched into pending; 0 = level sources.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- io_src  in  N_SRC  raw interrupt source lines.
- io_en_wr  in  1  enable-mask write strobe.
- io_en_wdata  in  N_SRC  new enable mask.
- io_en  out  N_SRC  current enable mask.
- io_pending  out  N_SRC  current pending vector.
- io_irq  out  1  interrupt request to the core.
- io_irq_cause  out  CAUSE_W  {1'b1, source index}; all zeros when io_irq=0.
- io_claim  in  1  core accepts the presented interrupt.
- io_complete  in  1  core finished servicing the claimed interrupt.

Behaviour:
- Reset (reset=0 at a clk edge): src_q=0, pending=0, enable=0, state=IDLE, io_irq=0, io_irq_cause=0, io_en=0, io_pending=0.
- Pending, EDGE=1: pending_next = (pending & ~clr) | (io_src & ~src_q); src_q <= io_src every cycle.
- Pending, EDGE=0: pending_next = io_src, registered; clr has no effect.
- Set beats clear: a new edge on the claimed source in the claim cycle leaves its pending bit set.
- Enable: io_en_wr=1 loads io_en_wdata at the edge. The new mask is used for arbitration from the next cycle.
- Arbitration: eligible = pending & enable. The winner is the lowest set index (index 0 has highest priority).
- State IDLE:
  - io_irq=0.
  - If eligible != 0: latch the winner index into sel, then go to ASSERT.
- State ASSERT:
  - io_irq=1; io_irq_cause = {1'b1, sel zero-extended to CAUSE_W-1}. The cause stays frozen while in ASSERT; a higher-priority arrival does not preempt.
  - If eligible[sel]=0 (source masked, or level dropped) and io_claim=0: go to IDLE next cycle; no claim takes place.
  - If io_claim=1: clr=onehot(sel) for that cycle, then go to SERVICE. io_claim takes precedence over withdrawal in the same cycle.
- State SERVICE:
  - io_irq=0 and io_irq_cause=0; no new interrupt is presented.
  - io_complete=1 → IDLE.
- Ignored inputs: io_claim outside ASSERT; io_complete outside SERVICE.
- Latency: io_src rises and is first sampled at edge k → pending bit visible after edge k → io_irq high after edge k+1 (2 cycles). After io_complete, a still-eligible source reasserts io_irq 2 cycles later (via IDLE).
- Mid-operation reset: returns to IDLE and clears all state in one cycle regardless of state. Any claim in flight is dropped.
- Width: the index is zero-extended into CAUSE_W-1 bits. Index bits above the source index are 0.

Test Plan:
- Reset for 2 cycles, then release → io_irq=0, io_irq_cause=0, io_en=0, io_pending=0.
- EDGE=1, io_en=4'b1111, pulse io_src[2] for 1 cycle → io_pending=4'b0100; io_irq=1 with io_irq_cause=6'h22 two cycles after sampling; io_claim → io_pending=0, io_irq=0; io_complete → IDLE, no reassert.
- io_src[3] and io_src[1] rise in the same cycle → cause 6'h21 first; after claim/complete, cause 6'h23 appears 2 cycles after io_complete.
- Pending[0] set while io_en=0 → io_irq stays 0; write io_en=4'b0001 → io_irq=1 with cause 6'h20 two cycles later.
- In ASSERT with sel=2, write io_en=0 → io_irq drops next cycle and io_pending[2] stays 1. Separately, a new io_src[2] edge in the claim cycle → io_pending[2] remains 1.
- EDGE=0: hold io_src[1]=1, then claim and complete → io_irq reasserts with 6'h21. Assert reset mid-SERVICE → IDLE and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/irq_cause_ctrl.sv
// Parametrised interrupt cause controller.
//
// Collects N_SRC interrupt lines into a pending vector, masks it with a
// software-written enable vector, picks the lowest-index eligible source and
// presents it to the core as {1'b1, index}. A claim/complete handshake with
// the core's trap logic clears the pending bit (edge mode) and holds off new
// requests until the handler finishes.
//
// Ports:
//   clk           clock
//   reset         synchronous active-low reset
//   io_src        raw interrupt source lines
//   io_en_wr      enable-mask write strobe
//   io_en_wdata   new enable mask
//   io_en         current enable mask
//   io_pending    current pending vector
//   io_irq        interrupt request to the core
//   io_irq_cause  {1'b1, source index} while requesting, else all zeros
//   io_claim      core accepts the presented interrupt
//   io_complete   core finished servicing the claimed interrupt
//
// CAUSE_W must be at least 2 and satisfy 2^(CAUSE_W-1) >= N_SRC.
module irq_cause_ctrl #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned CAUSE_W = 6,
  parameter bit          EDGE    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   io_src,
  input  logic               io_en_wr,
  input  logic [N_SRC-1:0]   io_en_wdata,
  output logic [N_SRC-1:0]   io_en,
  output logic [N_SRC-1:0]   io_pending,
  output logic               io_irq,
  output logic [CAUSE_W-1:0] io_irq_cause,
  input  logic               io_claim,
  input  logic               io_complete
);

  localparam int unsigned IDX_W = CAUSE_W - 1;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StService
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   src_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   en_q, en_d;
  logic [IDX_W-1:0]   sel_q, sel_d;

  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   sel_hot;
  logic [N_SRC-1:0]   clr;
  logic [IDX_W-1:0]   win;
  logic               any_eligible;
  logic               sel_eligible;

  assign eligible     = pending_q & en_q;
  assign any_eligible = |eligible;

  // Fixed priority: scanning downward leaves the lowest set index as winner.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win = IDX_W'(i);
    end
  end

  // One-hot of the latched selection; avoids indexing with a possibly
  // wider-than-needed sel value.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_hot[i] = (sel_q == IDX_W'(i));
    end
  end

  assign sel_eligible = |(eligible & sel_hot);

  // FSM next state, claim-driven clear and outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    clr          = '0;
    io_irq       = 1'b0;
    io_irq_cause = '0;
    unique case (state_q)
      StIdle: begin
        if (any_eligible) begin
          sel_d   = win;
          state_d = StAssert;
        end
      end
      StAssert: begin
        io_irq       = 1'b1;
        io_irq_cause = {1'b1, sel_q};
        // A claim wins over a same-cycle withdrawal of the source.
        if (io_claim) begin
          clr     = sel_hot;
          state_d = StService;
        end else if (!sel_eligible) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (io_complete) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending update. In edge mode a fresh edge sets the bit even when the
  // same cycle's claim clears it.
  always_comb begin
    if (EDGE) begin
      pending_d = (pending_q & ~clr) | (io_src & ~src_q);
    end else begin
      pending_d = io_src;
    end
  end

  assign en_d = io_en_wr ? io_en_wdata : en_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      src_q     <= '0;
      pending_q <= '0;
      en_q      <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= io_src;
      pending_q <= pending_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
    end
  end

  assign io_en      = en_q;
  assign io_pending = pending_q;

endmodule

// File: tb/tb_irq_cause_ctrl.sv
module tb_irq_cause_ctrl;

  logic       clk = 1'b0;
  logic       reset;

  // Edge-mode instance signals.
  logic [3:0] src, en_wdata, en, pend;
  logic       en_wr, claim, complete, irq;
  logic [5:0] cause;

  // Level-mode instance signals.
  logic [3:0] l_src, l_en_wdata, l_en, l_pend;
  logic       l_en_wr, l_claim, l_complete, l_irq;
  logic [5:0] l_cause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  irq_cause_ctrl #(.N_SRC(4), .CAUSE_W(6), .EDGE(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_src       (src),
    .io_en_wr     (en_wr),
    .io_en_wdata  (en_wdata),
    .io_en        (en),
    .io_pending   (pend),
    .io_irq       (irq),
    .io_irq_cause (cause),
    .io_claim     (claim),
    .io_complete  (complete)
  );

  irq_cause_ctrl #(.N_SRC(4), .CAUSE_W(6), .EDGE(1'b0)) dut_lvl (
    .clk          (clk),
    .reset        (reset),
    .io_src       (l_src),
    .io_en_wr     (l_en_wr),
    .io_en_wdata  (l_en_wdata),
    .io_en        (l_en),
    .io_pending   (l_pend),
    .io_irq       (l_irq),
    .io_irq_cause (l_cause),
    .io_claim     (l_claim),
    .io_complete  (l_complete)
  );

  typedef struct {
    logic [3:0] src;
    logic       en_wr;
    logic [3:0] wdata;
    logic       claim;
    logic       complete;
    logic [3:0] exp_en;
    logic [3:0] exp_pend;
    logic       exp_irq;
    logic [5:0] exp_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] s, logic w, logic [3:0] wd, logic c, logic cp,
                              logic [3:0] e_en, logic [3:0] e_p, logic e_i, logic [5:0] e_c);
    vec_t v;
    v.src = s; v.en_wr = w; v.wdata = wd; v.claim = c; v.complete = cp;
    v.exp_en = e_en; v.exp_pend = e_p; v.exp_irq = e_i; v.exp_cause = e_c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each record: inputs applied for one cycle, expected outputs after that edge.
    //            src     wr  wdata   clm cmp  en      pend    irq  cause
    vecs.push_back(mk(4'b0000, 1, 4'b1111, 0, 0, 4'b1111, 4'b0000, 0, 6'h00)); // 0 enable all
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 0, 4'b1111, 4'b0100, 0, 6'h00)); // 1 pulse src2
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0100, 1, 6'h22)); // 2 assert
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 6'h00)); // 3 claim
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 6'h00)); // 4 service
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b1111, 4'b0000, 0, 6'h00)); // 5 complete
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 6'h00)); // 6 claim in idle ignored
    vecs.push_back(mk(4'b1010, 0, 4'b0000, 0, 0, 4'b1111, 4'b1010, 0, 6'h00)); // 7 src3+src1
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b1010, 1, 6'h21)); // 8 src1 wins
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b1111, 4'b1010, 1, 6'h21)); // 9 complete ignored
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b1000, 0, 6'h00)); // 10 claim
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b1111, 4'b1000, 0, 6'h00)); // 11 complete
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b1000, 1, 6'h23)); // 12 src3 follows
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 6'h00)); // 13 claim
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b1111, 4'b0000, 0, 6'h00)); // 14 complete
    vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 6'h00)); // 15 mask all
    vecs.push_back(mk(4'b0001, 0, 4'b0000, 0, 0, 4'b0000, 4'b0001, 0, 6'h00)); // 16 src0 masked
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0001, 0, 6'h00)); // 17
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0001, 0, 6'h00)); // 18
    vecs.push_back(mk(4'b0000, 1, 4'b0001, 0, 0, 4'b0001, 4'b0001, 0, 6'h00)); // 19 enable src0
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 4'b0001, 1, 6'h20)); // 20 assert
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 6'h00)); // 21 claim
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 0, 6'h00)); // 22 complete
    vecs.push_back(mk(4'b0100, 1, 4'b1111, 0, 0, 4'b1111, 4'b0100, 0, 6'h00)); // 23 src2 rises
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 0, 4'b1111, 4'b0100, 1, 6'h22)); // 24 assert
    vecs.push_back(mk(4'b0100, 1, 4'b0000, 0, 0, 4'b0000, 4'b0100, 1, 6'h22)); // 25 mask write
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 0, 6'h00)); // 26 withdrawn
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 0, 6'h00)); // 27 still pending
    vecs.push_back(mk(4'b0000, 1, 4'b1111, 0, 0, 4'b1111, 4'b0100, 0, 6'h00)); // 28 re-enable
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0100, 1, 6'h22)); // 29 assert
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 1, 0, 4'b1111, 4'b0100, 0, 6'h00)); // 30 set beats clear
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b1111, 4'b0100, 0, 6'h00)); // 31 complete
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 4'b1111, 4'b0100, 1, 6'h22)); // 32 reassert
    vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0100, 1, 6'h22)); // 33 mask write
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 6'h00)); // 34 claim beats withdraw
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 6'h00)); // 35 complete

    reset = 1'b0;
    src = '0; en_wr = 1'b0; en_wdata = '0; claim = 1'b0; complete = 1'b0;
    l_src = '0; l_en_wr = 1'b0; l_en_wdata = '0; l_claim = 1'b0; l_complete = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("reset irq", 32'(irq), 32'd0);
    check("reset cause", 32'(cause), 32'd0);
    check("reset en", 32'(en), 32'd0);
    check("reset pending", 32'(pend), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      src      = vecs[i].src;
      en_wr    = vecs[i].en_wr;
      en_wdata = vecs[i].wdata;
      claim    = vecs[i].claim;
      complete = vecs[i].complete;
      tick();
      check($sformatf("vec%0d en", i), 32'(en), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d pending", i), 32'(pend), 32'(vecs[i].exp_pend));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("vec%0d cause", i), 32'(cause), 32'(vecs[i].exp_cause));
    end
    src = '0; en_wr = 1'b0; claim = 1'b0; complete = 1'b0;

    // Level mode: a held source reasserts after claim/complete.
    l_en_wr = 1'b1; l_en_wdata = 4'b1111;
    tick();
    l_en_wr = 1'b0;
    check("lvl en", 32'(l_en), 32'hf);
    l_src = 4'b0010;
    tick();
    check("lvl pending", 32'(l_pend), 32'h2);
    check("lvl irq early", 32'(l_irq), 32'd0);
    tick();
    check("lvl irq", 32'(l_irq), 32'd1);
    check("lvl cause", 32'(l_cause), 32'h21);
    l_claim = 1'b1;
    tick();
    l_claim = 1'b0;
    check("lvl claim irq", 32'(l_irq), 32'd0);
    check("lvl claim pending", 32'(l_pend), 32'h2);
    l_complete = 1'b1;
    tick();
    l_complete = 1'b0;
    check("lvl complete irq", 32'(l_irq), 32'd0);
    tick();
    check("lvl reassert irq", 32'(l_irq), 32'd1);
    check("lvl reassert cause", 32'(l_cause), 32'h21);
    l_claim = 1'b1;
    tick();
    l_claim = 1'b0;
    check("lvl service irq", 32'(l_irq), 32'd0);

    // Reset in the middle of SERVICE.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst irq", 32'(l_irq), 32'd0);
    check("midrst cause", 32'(l_cause), 32'd0);
    check("midrst en", 32'(l_en), 32'd0);
    check("midrst pending", 32'(l_pend), 32'd0);
    tick();
    check("postrst pending", 32'(l_pend), 32'h2);
    tick();
    check("postrst irq masked", 32'(l_irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
